// File: rtl/ucode_seq.sv
// Microcode sequencer: accepts one instruction in IDLE, then walks its micro-steps in EXEC and
// drives one-hot bus read/write selects. HLT parks the sequencer in HALT until rst.
module ucode_seq #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4+DW-1:0] instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [DW-1:0] im,
  output logic [7:0]    rs,
  output logic [7:0]    ws,
  output logic [1:0]    alu_op,
  output logic          done,
  output logic          illegal,
  output logic          halted,
  output logic [7:0]    icount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDIA = 4'h1;
  localparam logic [3:0] OP_LDIB = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_OUT  = 4'h6;
  localparam logic [3:0] OP_HLT  = 4'hF;

  state_t        r_state;
  state_t        w_next_state;
  logic [1:0]    r_step;
  logic [1:0]    w_next_step;
  logic [3:0]    r_op;
  logic [DW-1:0] r_im;
  logic [7:0]    r_icount;
  logic          w_accept;
  logic          w_last;

  assign w_accept    = (r_state == S_IDLE) && instr_valid;
  assign instr_ready = (r_state == S_IDLE);
  assign halted      = (r_state == S_HALT);
  assign im          = r_im;
  assign icount      = r_icount;

  // ADD and SUB are the only three-step opcodes; everything else finishes in step 1.
  always_comb begin
    w_last = 1'b0;
    if ((r_op == OP_ADD) || (r_op == OP_SUB)) begin
      w_last = (r_step == 2'd3);
    end else begin
      w_last = 1'b1;
    end
  end

  // Next-state and step-counter logic.
  always_comb begin
    w_next_state = r_state;
    w_next_step  = r_step;
    case (r_state)
      S_IDLE: begin
        w_next_step = 2'd1;
        if (instr_valid) begin
          w_next_state = S_EXEC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_EXEC: begin
        if (w_last) begin
          w_next_step  = 2'd1;
          w_next_state = (r_op == OP_HLT) ? S_HALT : S_IDLE;
        end else begin
          w_next_step  = r_step + 2'd1;
          w_next_state = S_EXEC;
        end
      end
      S_HALT: begin
        w_next_state = S_HALT;
        w_next_step  = 2'd1;
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_step  = 2'd1;
      end
    endcase
  end

  // State, step, latched instruction fields and accept counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_step   <= 2'd1;
      r_op     <= 4'h0;
      r_im     <= {DW{1'b0}};
      r_icount <= 8'd0;
    end else begin
      r_state <= w_next_state;
      r_step  <= w_next_step;
      if (w_accept) begin
        r_op     <= instr[DW+3:DW];
        r_im     <= instr[DW-1:0];
        r_icount <= r_icount + 8'd1;
      end else begin
        r_op     <= r_op;
        r_im     <= r_im;
        r_icount <= r_icount;
      end
    end
  end

  // Moore decode of the bus selects from state, step and latched opcode only.
  always_comb begin
    rs      = 8'h00;
    ws      = 8'h00;
    alu_op  = 2'b00;
    done    = 1'b0;
    illegal = 1'b0;
    if (r_state == S_EXEC) begin
      done = w_last && (r_op != OP_HLT);
      case (r_op)
        OP_NOP:  begin rs = 8'h00; ws = 8'h00; end
        OP_LDIA: begin rs = 8'h20; ws = 8'h08; end
        OP_LDIB: begin rs = 8'h20; ws = 8'h04; end
        OP_MOV:  begin rs = 8'h01; ws = 8'h04; end
        OP_ADD, OP_SUB: begin
          case (r_step)
            2'd1:    begin rs = 8'h01; ws = 8'h01; end
            2'd2:    begin rs = 8'h02; ws = 8'h02; end
            2'd3:    begin
              rs     = 8'h04;
              ws     = 8'h08;
              alu_op = (r_op == OP_SUB) ? 2'b01 : 2'b00;
            end
            default: begin rs = 8'h00; ws = 8'h00; end
          endcase
        end
        OP_OUT:  begin rs = 8'h01; ws = 8'h10; end
        OP_HLT:  begin rs = 8'h00; ws = 8'h00; end
        default: begin illegal = 1'b1; end
      endcase
    end else begin
      rs = 8'h00;
      ws = 8'h00;
    end
  end

endmodule

// File: doc/ucode_seq.md
UCODE_SEQ -- requirements
Module: ucode_seq

Interface
REQ-001 Parameter DW, default 4: width of the immediate field and of the im output.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port instr, input, 4+DW: instruction; [7:4] is the opcode and [3:0] is the immediate.
REQ-005 Port instr_valid, input, 1: instr is valid this cycle.
REQ-006 Port instr_ready, output, 1: the sequencer accepts instr this cycle.
REQ-007 Port im, output, DW: latched immediate, driven to the immediate buffer of the register stage.
REQ-008 Port rs, output, 8: one-hot bus-read selects; rs0=A, rs1=B, rs2=ALU result, rs5=immediate buffer; all others are unused and held 0.
REQ-009 Port ws, output, 8: one-hot bus-write selects; ws0=ALU X, ws1=ALU Y, ws2=B, ws3=A, ws4=OUT; all others are unused and held 0.
REQ-010 Port alu_op, output, 2: ALU operation, 00=ADD, 01=SUB, else 00.
REQ-011 Port done, output, 1: one-cycle pulse in the last micro-step of an instruction.
REQ-012 Port illegal, output, 1: one-cycle pulse in the single step of an undefined opcode.
REQ-013 Port halted, output, 1: sequencer is in HALT.
REQ-014 Port icount, output, 8: count of accepted instructions.

Function
REQ-015 FSM states: IDLE, EXEC, HALT; a 2-bit step counter runs from 1 to 3 inside EXEC.
REQ-016 IDLE: instr_ready=1 and rs=ws=0.
REQ-017 IDLE, instr_valid=1:
- latch the opcode and im;
- increment icount, wrapping 255 to 0;
- go to EXEC with step=1 on the next cycle.
REQ-018 IDLE, instr_valid=0: stay in IDLE; im holds its value.
REQ-019 instr_ready=0 in EXEC and HALT; instr_valid is ignored in those states and icount does not change.
REQ-020 Outputs are Moore: rs, ws, alu_op, done and illegal decode only from registered state, step and latched opcode.
REQ-021 Step table (one cycle per step):
- 0x0 NOP: step 1 has rs=ws=0.
- 0x1 LDI A: step 1 drives rs5 and ws3.
- 0x2 LDI B: step 1 drives rs5 and ws2.
- 0x3 MOV A to B: step 1 drives rs0 and ws2.
- 0x4 ADD: step 1 drives rs0 and ws0; step 2 drives rs1 and ws1; step 3 drives rs2 and ws3 with alu_op=00.
- 0x5 SUB: same as ADD, with alu_op=01 in step 3.
- 0x6 OUT A: step 1 drives rs0 and ws4.
- 0xF HLT: step 1 has rs=ws=0, then go to HALT.
- Any other opcode: step 1 has rs=ws=0 and illegal=1.
REQ-022 In every cycle rs and ws are each zero or one-hot; any other value is a design error.
REQ-023 done=1 exactly in the final step of every opcode except HLT; after that step the FSM returns to IDLE.
REQ-024 Instruction latency is 1 accept cycle plus N steps, with N = 1 or 3; the minimum issue interval is 2 cycles.
REQ-025 alu_op = 00 in every cycle that is not step 3 of SUB.
REQ-026 HALT: halted=1, rs=ws=0, instr_ready=0; the sequencer leaves HALT only on rst.
REQ-027 im holds its value from acceptance until the next acceptance.

Reset
REQ-028 When rst=1 at an edge, on the next cycle:
- state=IDLE, step=1;
- rs=0, ws=0, alu_op=00, im=0, icount=0;
- done=0, illegal=0, halted=0, instr_ready=1.
REQ-029 rst takes priority over instr_valid and over any EXEC or HALT activity.
REQ-030 rst during a step aborts the instruction with no done pulse.

Verification
REQ-031 LDI A, instr=0x19 with valid held for 1 cycle -> next cycle im=9, rs=0x20, ws=0x08, done=1; following cycle is IDLE with ready=1 and icount=1.
REQ-032 ADD, instr=0x40 -> three consecutive cycles of (rs,ws) = (0x01,0x01), (0x02,0x02), (0x04,0x08); alu_op=00; done only in the third cycle.
REQ-033 Back-to-back stream of valid=1 carrying SUB then OUT -> SUB steps with alu_op=01 in step 3; one IDLE accept cycle; OUT step with rs=0x01, ws=0x10; icount increments by 2.
REQ-034 Opcode 0x9 -> illegal pulses for 1 cycle, rs=ws=0, done=1; then HLT (0xF0) -> halted=1 and ready=0, and further valid instructions are ignored until rst.
REQ-035 rst asserted in step 2 of ADD -> next cycle rs=ws=0, no done pulse, icount=0, ready=1.
REQ-036 Accept 256 NOPs -> icount wraps to 0.
